// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR sequencing controller
//   sterownik_stan_t : controller FSM states
//   WSP_W            : coefficient-count width
//   N_MAX            : largest legal coefficient count
//   MAC_LAT_W        : width of the MAC-drain down-counter
package fir_pkg;
    localparam int WSP_W     = 6;
    localparam int N_MAX     = 32;
    localparam int MAC_LAT_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } sterownik_stan_t;
endpackage

// File: rtl/sterownik_fir.sv
// sterownik_fir: sequencing controller for one FIR output computation
//   clk, rst_n              : clock, asynchronous active-low reset
//   cfg_we, cfg_wsp         : coefficient-count write (legal 1..N_MAX, IDLE only)
//   cfg_err                 : one-cycle pulse after a rejected config write
//   probka_valid/ready      : input sample handshake
//   probka_we               : write accepted sample into the delay line
//   wsp, zapisz_wsp         : shadow count and its load strobe to the loop counter
//   reset_petla, petla_en   : loop counter address clear / advance
//   full                    : loop counter done (registered, after last address)
//   acc_clr, acc_en         : accumulator clear / accumulate
//   wynik_valid/ready       : result handshake
//   busy                    : controller not in IDLE
module sterownik_fir #(
    parameter int WSP_W   = fir_pkg::WSP_W,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [WSP_W-1:0] cfg_wsp,
    output logic             cfg_err,
    input  logic             probka_valid,
    output logic             probka_ready,
    output logic             probka_we,
    output logic [WSP_W-1:0] wsp,
    output logic             zapisz_wsp,
    output logic             reset_petla,
    output logic             petla_en,
    input  logic             full,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             wynik_valid,
    input  logic             wynik_ready,
    output logic             busy
);
    import fir_pkg::*;

    sterownik_stan_t        stan, stan_nx;
    logic [MAC_LAT_W-1:0]   cnt;
    logic                   cfg_ok;
    logic                   przyjmij;
    logic                   cfg_dobry;

    assign przyjmij  = (stan == IDLE) && probka_valid && cfg_ok;
    // A sample accepted in the same cycle wins over a config write.
    assign cfg_dobry = cfg_we && (stan == IDLE) && !przyjmij &&
                       (cfg_wsp != '0) && (int'(cfg_wsp) <= N_MAX);

    always_comb begin
        stan_nx = (stan == IDLE)  ? (przyjmij ? LOAD : IDLE) :
                  (stan == LOAD)  ? MAC :
                  (stan == MAC)   ? (full ? ((MAC_LAT > 0) ? DRAIN : OUT) : MAC) :
                  (stan == DRAIN) ? ((cnt == '0) ? OUT : DRAIN) :
                  (stan == OUT && !wynik_ready) ? OUT : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stan <= IDLE;
            cnt  <= '0;
        end else begin
            stan <= stan_nx;
            // Loaded with MAC_LAT-1 so DRAIN lasts exactly MAC_LAT cycles.
            if (stan == MAC && full)
                cnt <= MAC_LAT_W'(MAC_LAT - 1);
            else if (stan == DRAIN)
                cnt <= cnt - MAC_LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsp        <= '0;
            cfg_ok     <= 1'b0;
            zapisz_wsp <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            zapisz_wsp <= cfg_dobry;
            cfg_err    <= cfg_we && !cfg_dobry;
            if (cfg_dobry) begin
                wsp    <= cfg_wsp;
                cfg_ok <= 1'b1;
            end
        end
    end

    assign probka_ready = (stan == IDLE) && cfg_ok;
    assign probka_we    = (stan == LOAD);
    assign acc_clr      = (stan == LOAD);
    assign reset_petla  = (stan == LOAD);
    assign petla_en     = (stan == MAC);
    // The cycle full arrives the counter already holds past the last address.
    assign acc_en       = (stan == MAC) && !full;
    assign wynik_valid  = (stan == OUT);
    assign busy         = (stan != IDLE);
endmodule
